alu_cmd_issuer: RTL and testbench

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_cmd_fifo.sv | 52 +++++
 rtl/alu_cmd_issuer.sv | 140 ++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, issuer FSM encoding and divide-by-zero result
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_DIV  = 3'b010;
   localparam logic [2:0] OP_MOD  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_XNOR = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_HOLD  = 2'b11
   } issuer_state_e;

   // Wide enough for any supported WIDTH; users slice [WIDTH:0].
   localparam int                  MAX_WIDTH   = 64;
   localparam logic [MAX_WIDTH:0]  DIV0_RESULT = '1;

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO; push is ignored when full, pop when empty
module alu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 35
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [DW-1:0] pop_data_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          wr_en, rd_en;

   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign wr_en      = push_i && !full_o;
   assign rd_en      = pop_i && !empty_o;
   assign pop_data_o = mem_q[rd_ptr_q];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - queues ALU commands, issues them one at a time, returns responses
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [2:0]       alu_select,
   input  logic [WIDTH:0]   alu_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH:0]   rsp_data,
   output logic             rsp_err,
   output logic [2:0]       rsp_op
);

   localparam int DW = 3 + 2*WIDTH;

   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DW-1:0]    fifo_wdata, fifo_rdata;
   logic [2:0]       head_op;
   logic [WIDTH-1:0] head_a, head_b;

   issuer_state_e    state_q, state_d;
   logic [WIDTH-1:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
   logic [2:0]       alu_sel_q, alu_sel_d;
   logic [WIDTH:0]   rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;
   logic [2:0]       rsp_op_q, rsp_op_d;
   logic             rsp_valid_q, rsp_valid_d;

   assign fifo_wdata                 = {cmd_op, cmd_a, cmd_b};
   assign {head_op, head_a, head_b}  = fifo_rdata;
   assign cmd_ready                  = !fifo_full;
   assign fifo_push                  = cmd_valid && !fifo_full;

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (fifo_push),
      .push_data_i (fifo_wdata),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_rdata),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         alu_in1_q   <= '0;
         alu_in2_q   <= '0;
         alu_sel_q   <= OP_ADD;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rsp_op_q    <= 3'b000;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         alu_in1_q   <= alu_in1_d;
         alu_in2_q   <= alu_in2_d;
         alu_sel_q   <= alu_sel_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         rsp_op_q    <= rsp_op_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      alu_in1_d   = alu_in1_q;
      alu_in2_d   = alu_in2_q;
      alu_sel_d   = alu_sel_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      rsp_op_d    = rsp_op_q;
      rsp_valid_d = rsp_valid_q;
      fifo_pop    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               rsp_op_d = head_op;
               if (is_div_op(head_op) && (head_b == '0)) begin
                  rsp_err_d  = 1'b1;
                  rsp_data_d = DIV0_RESULT[WIDTH:0];
                  state_d    = ST_HOLD;
               end else begin
                  alu_in1_d = head_a;
                  alu_in2_d = head_b;
                  alu_sel_d = head_op;
                  state_d   = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            rsp_data_d  = alu_out;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            // A divide-by-zero enters HOLD with valid low; it rises one cycle later.
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign alu_in1    = alu_in1_q;
   assign alu_in2    = alu_in2_q;
   assign alu_select = alu_sel_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;
   assign rsp_op     = rsp_op_q;
   assign rsp_valid  = rsp_valid_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - directed bench for alu_cmd_issuer with a registered ALU model
module tb_alu_cmd_issuer;
   import alu_pkg::*;

   localparam int DEPTH = 4;
   localparam int WIDTH = 16;

   logic             clock = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_a, cmd_b;
   logic [WIDTH-1:0] alu_in1, alu_in2;
   logic [2:0]       alu_select;
   logic [WIDTH:0]   alu_out = '0;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH:0]   rsp_data;
   logic             rsp_err;
   logic [2:0]       rsp_op;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   alu_cmd_issuer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .alu_select (alu_select),
      .alu_out    (alu_out),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .rsp_op     (rsp_op)
   );

   // Registered ALU: one-cycle latency from operands to alu_out.
   always_ff @(posedge clock) begin
      case (alu_select)
         OP_ADD:  alu_out <= {1'b0, alu_in1} + {1'b0, alu_in2};
         OP_SUB:  alu_out <= {1'b0, alu_in1} - {1'b0, alu_in2};
         OP_DIV:  alu_out <= (alu_in2 == '0) ? '0 : {1'b0, alu_in1 / alu_in2};
         OP_MOD:  alu_out <= (alu_in2 == '0) ? '0 : {1'b0, alu_in1 % alu_in2};
         OP_AND:  alu_out <= {1'b0, alu_in1 & alu_in2};
         OP_OR:   alu_out <= {1'b0, alu_in1 | alu_in2};
         OP_XOR:  alu_out <= {1'b0, alu_in1 ^ alu_in2};
         default: alu_out <= {1'b0, ~(alu_in1 ^ alu_in2)};
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("send_timeout", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic expect_rsp(input string tag, input logic [WIDTH:0] data, input logic err,
                             input logic [2:0] op);
      int n = 0;
      while (!rsp_valid && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_data"},  32'(rsp_data),  32'(data));
      check({tag, "_err"},   32'(rsp_err),   32'(err));
      check({tag, "_op"},    32'(rsp_op),    32'(op));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic seen;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_a     = '0;
      cmd_b     = '0;
      rsp_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_rsp_valid", 32'(rsp_valid),  32'd0);
      check("rst_cmd_ready", 32'(cmd_ready),  32'd1);
      check("rst_rsp_data",  32'(rsp_data),   32'd0);
      check("rst_rsp_err",   32'(rsp_err),    32'd0);
      check("rst_rsp_op",    32'(rsp_op),     32'd0);
      check("rst_alu_in1",   32'(alu_in1),    32'd0);
      check("rst_alu_in2",   32'(alu_in2),    32'd0);
      check("rst_alu_sel",   32'(alu_select), 32'd0);

      // add with carry-out, latency N+3
      send(OP_ADD, 16'hFFFF, 16'h0001);
      check("add_lat_n0", 32'(rsp_valid), 32'd0);
      tick();
      check("add_lat_n1",  32'(rsp_valid), 32'd0);
      check("add_alu_in1", 32'(alu_in1),   32'h0000FFFF);
      check("add_alu_in2", 32'(alu_in2),   32'h00000001);
      tick();
      check("add_lat_n2", 32'(rsp_valid), 32'd0);
      tick();
      check("add_lat_n3", 32'(rsp_valid), 32'd1);
      expect_rsp("add", 17'h10000, 1'b0, OP_ADD);
      check("add_released", 32'(rsp_valid), 32'd0);

      // in-order sub/div/mod
      send(OP_SUB, 16'd3, 16'd5);
      send(OP_DIV, 16'd100, 16'd7);
      send(OP_MOD, 16'd100, 16'd7);
      expect_rsp("sub", 17'h1FFFE, 1'b0, OP_SUB);
      expect_rsp("div", 17'd14,    1'b0, OP_DIV);
      expect_rsp("mod", 17'd2,     1'b0, OP_MOD);

      // divide by zero, latency N+2, ALU not issued
      send(OP_DIV, 16'd9, 16'd0);
      tick();
      check("dz_lat_n1", 32'(rsp_valid), 32'd0);
      tick();
      check("dz_lat_n2",   32'(rsp_valid),  32'd1);
      check("dz_alu_sel",  32'(alu_select), 32'(OP_MOD));
      check("dz_alu_in2",  32'(alu_in2),    32'd7);
      expect_rsp("dz", 17'h1FFFF, 1'b1, OP_DIV);

      // backpressure: 5 commands with rsp_ready low
      send(OP_AND,  16'hF0F0, 16'hFF00);
      send(OP_OR,   16'hF0F0, 16'h0F0F);
      send(OP_XOR,  16'h1234, 16'hFFFF);
      send(OP_XNOR, 16'h1234, 16'hFFFF);
      send(OP_ADD,  16'd7,    16'd8);
      check("bp_full_ready", 32'(cmd_ready), 32'd0);
      check("bp_and_valid",  32'(rsp_valid), 32'd1);
      check("bp_and_data",   32'(rsp_data),  32'h0000F000);
      tick();
      tick();
      check("bp_still_full", 32'(cmd_ready), 32'd0);

      // full FIFO: pop and offered push on the same edge, push waits one edge
      cmd_valid = 1'b1;
      cmd_op    = OP_SUB;
      cmd_a     = 16'd0;
      cmd_b     = 16'd1;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("pp_ready_at_pop", 32'(cmd_ready), 32'd0);
      tick();
      check("pp_ready_after_pop", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      expect_rsp("bp_or",   17'h0FFFF, 1'b0, OP_OR);
      expect_rsp("bp_xor",  17'h0EDCB, 1'b0, OP_XOR);
      expect_rsp("bp_xnor", 17'h01234, 1'b0, OP_XNOR);
      expect_rsp("bp_add",  17'h0000F, 1'b0, OP_ADD);
      expect_rsp("pp_sub",  17'h1FFFF, 1'b0, OP_SUB);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen = seen | rsp_valid;
      end
      check("pp_no_extra", 32'(seen), 32'd0);

      // reset during WAIT with two queued commands
      send(OP_ADD, 16'd1, 16'd1);
      send(OP_ADD, 16'd2, 16'd2);
      send(OP_ADD, 16'd3, 16'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mr_cmd_ready", 32'(cmd_ready), 32'd1);
      check("mr_alu_in1",   32'(alu_in1),   32'd0);
      seen = rsp_valid;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen = seen | rsp_valid;
      end
      check("mr_no_rsp", 32'(seen), 32'd0);
      send(OP_ADD, 16'd2, 16'd3);
      expect_rsp("mr_next", 17'd5, 1'b0, OP_ADD);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
